// File: rtl/video_mode_pkg.sv
// Video timing modes, pipeline control types and scan-out geometry helpers.
package video_mode_pkg;

  typedef enum logic [1:0] {
    VMODE_640x480p60,
    VMODE_800x600p60,
    VMODE_TEST
  } video_mode_t;

  typedef struct packed {
    int unsigned h_res;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_res;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hsync_pos;  // 1: the sync pulse drives the pin high
    logic        vsync_pos;
  } video_timing_t;

  // Control bits that travel alongside a pixel through the read pipeline.
  // All-zero is a blank pixel with both syncs inactive.
  typedef struct packed {
    logic hsync_on;
    logic vsync_on;
    logic active;
    logic first;
  } pix_ctrl_t;

  function automatic video_timing_t mode_timing(video_mode_t mode);
    video_timing_t t;
    case (mode)
      VMODE_800x600p60: t = '{h_res: 800, h_fp: 40, h_sync: 128, h_bp: 88,
                              v_res: 600, v_fp: 1, v_sync: 4, v_bp: 23,
                              hsync_pos: 1'b1, vsync_pos: 1'b1};
      VMODE_TEST:       t = '{h_res: 8, h_fp: 2, h_sync: 2, h_bp: 2,
                              v_res: 4, v_fp: 1, v_sync: 1, v_bp: 1,
                              hsync_pos: 1'b0, vsync_pos: 1'b0};
      default:          t = '{h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                              v_res: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                              hsync_pos: 1'b0, vsync_pos: 1'b0};
    endcase
    return t;
  endfunction

  function automatic int unsigned h_total(video_timing_t t);
    return t.h_res + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(video_timing_t t);
    return t.v_res + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  function automatic int unsigned fb_width(video_timing_t t, int unsigned scale);
    return t.h_res / scale;
  endfunction

  function automatic int unsigned fb_height(video_timing_t t, int unsigned scale);
    return t.v_res / scale;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters plus sync, active-region and frame-boundary decode.
module video_timing
  import video_mode_pkg::*;
#(
  parameter video_mode_t VIDEO_MODE = VMODE_640x480p60
) (
  input  logic clk,
  input  logic rstn,
  output logic pix_valid,
  output logic hsync_on,
  output logic vsync_on,
  output logic active,
  output logic first_pixel,
  output logic line_end,
  output logic frame_end
);

  localparam video_timing_t T = mode_timing(VIDEO_MODE);
  localparam int unsigned H_TOTAL  = h_total(T);
  localparam int unsigned V_TOTAL  = v_total(T);
  localparam int unsigned XW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned YW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  // One spare bit so bounds equal to the total still compare correctly.
  localparam int unsigned XEW      = XW + 1;
  localparam int unsigned YEW      = YW + 1;
  localparam int unsigned H_RES    = T.h_res;
  localparam int unsigned V_RES    = T.v_res;
  localparam int unsigned HS_START = T.h_res + T.h_fp;
  localparam int unsigned HS_END   = HS_START + T.h_sync;
  localparam int unsigned VS_START = T.v_res + T.v_fp;
  localparam int unsigned VS_END   = VS_START + T.v_sync;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XEW-1:0] x_ext;
  logic [YEW-1:0] y_ext;
  // Low for the first edge after reset release so the scan starts at (0,0) there.
  logic run_q;

  assign x_ext     = {1'b0, x_q};
  assign y_ext     = {1'b0, y_q};
  assign pix_valid = run_q;

  // Decode of the current counter position.
  always_comb begin
    line_end    = (x_q == XW'(H_TOTAL - 1));
    frame_end   = line_end && (y_q == YW'(V_TOTAL - 1));
    first_pixel = (x_q == '0) && (y_q == '0);
    hsync_on    = (x_ext >= XEW'(HS_START)) && (x_ext < XEW'(HS_END));
    vsync_on    = (y_ext >= YEW'(VS_START)) && (y_ext < YEW'(VS_END));
    active      = (x_ext < XEW'(H_RES)) && (y_ext < YEW'(V_RES));
  end

  // Next raster position: x wraps into a y step, y wraps at the frame end.
  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (line_end) begin
      x_d = '0;
      y_d = frame_end ? '0 : y_q + YW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_q   <= '0;
      y_q   <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

endmodule

// File: rtl/display_scanout.sv
// Double-buffered framebuffer scan-out with integer upscaling and a
// latency-matched sync/colour pipeline.
module display_scanout
  import video_mode_pkg::*;
#(
  parameter video_mode_t VIDEO_MODE   = VMODE_640x480p60,
  parameter int          SCALE        = 1,
  parameter int          COLOR_BITS   = 4,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    active_buffer,
  output logic                    fb_rd_en,
  output logic [ADDR_WIDTH-1:0]   fb_addr,
  input  logic [3*COLOR_BITS-1:0] fb_data,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [COLOR_BITS-1:0]   vga_red,
  output logic [COLOR_BITS-1:0]   vga_green,
  output logic [COLOR_BITS-1:0]   vga_blue,
  output logic                    frame_start
);

  localparam video_timing_t T = mode_timing(VIDEO_MODE);
  localparam int unsigned H_RES     = T.h_res;
  localparam int unsigned V_RES     = T.v_res;
  localparam int unsigned FB_W      = fb_width(T, SCALE);
  localparam int unsigned FB_H      = fb_height(T, SCALE);
  localparam int unsigned BUF_WORDS = FB_W * FB_H;
  localparam longint unsigned NEED_WORDS = 2 * longint'(BUF_WORDS);
  localparam logic HS_POS = T.hsync_pos;
  localparam logic VS_POS = T.vsync_pos;

  if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
    $error("display_scanout: SCALE must be in 1..4");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("display_scanout: READ_LATENCY must be in 1..4");
  end
  if ((H_RES % SCALE) != 0 || (V_RES % SCALE) != 0) begin : g_bad_res
    $error("display_scanout: resolution not divisible by SCALE");
  end
  if ((ADDR_WIDTH < 64) && (NEED_WORDS > (64'd1 << ADDR_WIDTH))) begin : g_bad_addr
    $error("display_scanout: two buffers do not fit in ADDR_WIDTH");
  end

  logic pix_valid, tim_hsync, tim_vsync, tim_active, tim_first, line_end, frame_end;

  video_timing #(
    .VIDEO_MODE (VIDEO_MODE)
  ) u_timing (
    .clk         (clk),
    .rstn        (rstn),
    .pix_valid   (pix_valid),
    .hsync_on    (tim_hsync),
    .vsync_on    (tim_vsync),
    .active      (tim_active),
    .first_pixel (tim_first),
    .line_end    (line_end),
    .frame_end   (frame_end)
  );

  // Source-pixel tracking: sub-counters step the source column/line every
  // SCALE pixels, and the line base accumulates FB_W per source line.
  logic [1:0]            sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [ADDR_WIDTH-1:0] src_x_q, src_x_d, line_base_q, line_base_d;
  logic                  active_buffer_q, active_buffer_d;
  logic                  swap_ack_q, swap_ack_d;
  logic                  fb_rd_en_q;
  logic [ADDR_WIDTH-1:0] fb_addr_q, pix_addr, buf_base;
  logic                  fetch, swap_sample;

  // Next source position, mirrored from the raster counter advance.
  always_comb begin
    sub_x_d     = sub_x_q;
    src_x_d     = src_x_q;
    sub_y_d     = sub_y_q;
    line_base_d = line_base_q;
    if (pix_valid) begin
      if (line_end) begin
        sub_x_d = '0;
        src_x_d = '0;
        if (frame_end) begin
          sub_y_d     = '0;
          line_base_d = '0;
        end else if (sub_y_q == 2'(SCALE - 1)) begin
          sub_y_d     = '0;
          line_base_d = line_base_q + ADDR_WIDTH'(FB_W);
        end else begin
          sub_y_d = sub_y_q + 2'd1;
        end
      end else if (sub_x_q == 2'(SCALE - 1)) begin
        sub_x_d = '0;
        src_x_d = src_x_q + ADDR_WIDTH'(1);
      end else begin
        sub_x_d = sub_x_q + 2'd1;
      end
    end
  end

  // Buffer flip is decided only on the last pixel of a frame.
  always_comb begin
    swap_sample     = pix_valid && frame_end;
    swap_ack_d      = swap_sample && swap_req;
    active_buffer_d = active_buffer_q ^ swap_ack_d;
    buf_base        = active_buffer_q ? ADDR_WIDTH'(BUF_WORDS) : '0;
    pix_addr        = buf_base + line_base_q + src_x_q;
    fetch           = pix_valid && tim_active;
  end

  // Source tracking, buffer select and framebuffer request registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sub_x_q         <= '0;
      src_x_q         <= '0;
      sub_y_q         <= '0;
      line_base_q     <= '0;
      active_buffer_q <= 1'b0;
      swap_ack_q      <= 1'b0;
      fb_rd_en_q      <= 1'b0;
      fb_addr_q       <= '0;
    end else begin
      sub_x_q         <= sub_x_d;
      src_x_q         <= src_x_d;
      sub_y_q         <= sub_y_d;
      line_base_q     <= line_base_d;
      active_buffer_q <= active_buffer_d;
      swap_ack_q      <= swap_ack_d;
      fb_rd_en_q      <= fetch;
      if (fetch) begin
        fb_addr_q <= pix_addr;
      end
    end
  end

  // Control pipeline: stage 0 lines up with the read request, stage
  // READ_LATENCY with the returned data.
  pix_ctrl_t ctrl_in, ctrl_out;
  pix_ctrl_t ctrl_q [0:READ_LATENCY];

  // Blank control word unless the counter position is live.
  always_comb begin
    ctrl_in = '0;
    if (pix_valid) begin
      ctrl_in.hsync_on = tim_hsync;
      ctrl_in.vsync_on = tim_vsync;
      ctrl_in.active   = tim_active;
      ctrl_in.first    = tim_first;
    end
    ctrl_out = ctrl_q[READ_LATENCY];
  end

  // Delay line matching the framebuffer read latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i <= READ_LATENCY; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      ctrl_q[0] <= ctrl_in;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        ctrl_q[i] <= ctrl_q[i-1];
      end
    end
  end

  logic                  hsync_q, vsync_q, frame_start_q;
  logic [COLOR_BITS-1:0] red_q, green_q, blue_q;

  // Output pin registers; colour is forced to zero outside the active region.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hsync_q       <= ~HS_POS;
      vsync_q       <= ~VS_POS;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= ctrl_out.hsync_on ^ ~HS_POS;
      vsync_q       <= ctrl_out.vsync_on ^ ~VS_POS;
      frame_start_q <= ctrl_out.first;
      if (ctrl_out.active) begin
        red_q   <= fb_data[COLOR_BITS-1:0];
        green_q <= fb_data[2*COLOR_BITS-1:COLOR_BITS];
        blue_q  <= fb_data[3*COLOR_BITS-1:2*COLOR_BITS];
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign swap_ack      = swap_ack_q;
  assign active_buffer = active_buffer_q;
  assign fb_rd_en      = fb_rd_en_q;
  assign fb_addr       = fb_addr_q;
  assign vga_hsync     = hsync_q;
  assign vga_vsync     = vsync_q;
  assign vga_red       = red_q;
  assign vga_green     = green_q;
  assign vga_blue      = blue_q;
  assign frame_start   = frame_start_q;

endmodule
